// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the multi-channel PWM block.
// Mode and counter direction encodings, default datapath width.
package pwm_pkg;

  localparam int PWM_WIDTH = 32;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  localparam logic PWM_DIR_UP   = 1'b0;
  localparam logic PWM_DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with its own active compare register.
// Ports: clock, reset (async low), load, next_compare, count, enable, pulse.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] next_compare,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  output logic             pulse
);

  logic [WIDTH-1:0] compare;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      compare <= '0;
    end else if (load) begin
      compare <= next_compare;
    end
  end

  assign pulse = enable & (count < compare);

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM, edge/center aligned,
// shadowed period/mode/compare. Ports: clock, reset, pwm_* in/out.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          pwm_period,
  input  logic [CHANNELS*WIDTH-1:0] pwm_compare,
  input  logic                      pwm_mode,
  input  logic [CHANNELS-1:0]       pwm_enable,
  output logic [CHANNELS-1:0]       pwm_pulse,
  output logic                      pwm_fetch,
  output logic [WIDTH-1:0]          pwm_count
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_n;
  logic             dir;
  logic             dir_n;
  logic [WIDTH-1:0] period;
  logic             mode;

  logic             run;
  logic             last_edge;
  logic             last_center;
  logic             fetch;
  logic [WIDTH-1:0] count_inc;
  logic [CHANNELS-1:0] en_eff;

  assign run         = period != '0;
  assign count_inc   = count + WIDTH'(1);
  assign last_edge   = count_inc == period;
  assign last_center = (dir == PWM_DIR_DOWN) &&
                       (count == WIDTH'(1));

  // Idle (period 0) keeps fetch high so every edge reloads.
  always_comb begin
    fetch = 1'b1;
    if (run) begin
      if (mode == PWM_MODE_CENTER) begin
        fetch = last_center;
      end else begin
        fetch = last_edge;
      end
    end
  end

  always_comb begin
    count_n = count;
    dir_n   = dir;
    if (fetch) begin
      count_n = '0;
      dir_n   = PWM_DIR_UP;
    end else if (mode == PWM_MODE_EDGE) begin
      count_n = count_inc;
    end else if (dir == PWM_DIR_UP) begin
      count_n = count_inc;
      // Turn around on the cycle the peak is reached.
      if (count_inc == period) begin
        dir_n = PWM_DIR_DOWN;
      end
    end else begin
      count_n = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      dir    <= PWM_DIR_UP;
      period <= '0;
      mode   <= PWM_MODE_EDGE;
    end else begin
      count <= count_n;
      dir   <= dir_n;
      if (fetch) begin
        period <= pwm_period;
        mode   <= pwm_mode;
      end
    end
  end

  // Outputs stay low while idle regardless of loaded compares.
  assign en_eff = pwm_enable & {CHANNELS{run}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .load        (fetch),
      .next_compare(pwm_compare[i*WIDTH +: WIDTH]),
      .count       (count),
      .enable      (en_eff[i]),
      .pulse       (pwm_pulse[i])
    );
  end

  assign pwm_fetch = fetch;
  assign pwm_count = count;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi.
// Drives and samples on the falling clock edge.
module tb_pwm_multi;

  localparam int W = 32;
  localparam int C = 4;

  logic           clock;
  logic           reset;
  logic [W-1:0]   pwm_period;
  logic [C*W-1:0] pwm_compare;
  logic           pwm_mode;
  logic [C-1:0]   pwm_enable;
  logic [C-1:0]   pwm_pulse;
  logic           pwm_fetch;
  logic [W-1:0]   pwm_count;

  int errors = 0;
  int checks = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm_period (pwm_period),
    .pwm_compare(pwm_compare),
    .pwm_mode   (pwm_mode),
    .pwm_enable (pwm_enable),
    .pwm_pulse  (pwm_pulse),
    .pwm_fetch  (pwm_fetch),
    .pwm_count  (pwm_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_cmp(input int ch, input logic [W-1:0] v);
    pwm_compare[ch*W +: W] = v;
  endtask

  // Expected sequences, hand-derived.
  int e1_cnt[4] = '{0, 1, 2, 3};
  int e1_p0[4]  = '{1, 1, 0, 0};
  int e3_cnt[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  int e3_p0[8]  = '{1, 1, 0, 0, 0, 0, 0, 1};
  int e6_cnt[6] = '{0, 1, 2, 3, 4, 3};
  int e6_p0[6]  = '{1, 1, 1, 0, 0, 0};

  initial begin
    reset       = 1'b0;
    pwm_period  = 4;
    pwm_compare = '0;
    pwm_mode    = 1'b0;
    pwm_enable  = 4'b0001;
    set_cmp(0, 2);

    // Reset state
    #12;
    check("rst_count", pwm_count, 0);
    check("rst_pulse", 32'(pwm_pulse), 0);
    check("rst_fetch", 32'(pwm_fetch), 1);
    @(negedge clock);
    reset = 1'b1;

    // 1: edge P=4 compare 2
    for (int k = 0; k < 8; k++) begin
      step();
      check("t1_count", pwm_count, 32'(e1_cnt[k%4]));
      check("t1_pulse", 32'(pwm_pulse[0]), 32'(e1_p0[k%4]));
      check("t1_fetch", 32'(pwm_fetch), 32'(k%4 == 3));
    end

    // 2: shadowing, change compare at count 1
    step();
    step();
    check("t2_cnt1", pwm_count, 1);
    set_cmp(0, 3);
    check("t2_p_c1", 32'(pwm_pulse[0]), 1);
    step();
    check("t2_p_c2", 32'(pwm_pulse[0]), 0);
    step();
    check("t2_p_c3", 32'(pwm_pulse[0]), 0);
    check("t2_fetch", 32'(pwm_fetch), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_count", pwm_count, 32'(k));
      check("t2_pulse", 32'(pwm_pulse[0]), 32'(k < 3));
    end

    // 3: center P=4 compare 2
    pwm_mode = 1'b1;
    set_cmp(0, 2);
    for (int k = 0; k < 16; k++) begin
      step();
      check("t3_count", pwm_count, 32'(e3_cnt[k%8]));
      check("t3_pulse", 32'(pwm_pulse[0]), 32'(e3_p0[k%8]));
      check("t3_fetch", 32'(pwm_fetch), 32'(k%8 == 7));
    end

    // 4: compare 0 and compare > P, enable shutdown
    pwm_mode   = 1'b0;
    pwm_enable = 4'b0011;
    set_cmp(0, 0);
    set_cmp(1, 5);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_count", pwm_count, 32'(k));
      check("t4_pulse", 32'(pwm_pulse[1:0]), 32'h2);
    end
    step();
    step();
    pwm_enable = 4'b0001;
    #1;
    check("t4_off_p", 32'(pwm_pulse[1]), 0);
    check("t4_off_c", pwm_count, 1);
    check("t4_off_f", 32'(pwm_fetch), 0);
    step();
    check("t4_off_c2", pwm_count, 2);
    pwm_enable = 4'b0011;
    #1;
    check("t4_on_p", 32'(pwm_pulse[1]), 1);

    // 5: idle then start
    pwm_period = 0;
    set_cmp(0, 1);
    step();
    check("t5_pre_f", 32'(pwm_fetch), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_idle_c", pwm_count, 0);
      check("t5_idle_f", 32'(pwm_fetch), 1);
      check("t5_idle_p", 32'(pwm_pulse), 0);
    end
    pwm_period = 3;
    set_cmp(1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_count", pwm_count, 32'(k));
      check("t5_pulse", 32'(pwm_pulse[0]), 32'(k == 0));
    end
    check("t5_fetch", 32'(pwm_fetch), 1);

    // 6: reset at count 2 in center mode
    pwm_mode   = 1'b1;
    pwm_period = 4;
    set_cmp(0, 3);
    step();
    step();
    step();
    check("t6_pre_c", pwm_count, 2);
    reset = 1'b0;
    #1;
    check("t6_rst_c", pwm_count, 0);
    check("t6_rst_p", 32'(pwm_pulse), 0);
    check("t6_rst_f", 32'(pwm_fetch), 1);
    step();
    check("t6_hold_c", pwm_count, 0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t6_count", pwm_count, 32'(e6_cnt[k]));
      check("t6_pulse", 32'(pwm_pulse[0]), 32'(e6_p0[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
